// File: rtl/apb_reg_demux.sv
// APB3 slave that decodes one address window into NUM_PORTS register-bus ports,
// with decode-error response, per-access timeout and a registered single-outstanding response.
module apb_reg_demux #(
  parameter int                    NUM_PORTS      = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = {ADDR_WIDTH{1'b0}},
  parameter int                    PORT_ADDR_BITS = 12,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            psel_i,
  input  logic                            penable_i,
  input  logic                            pwrite_i,
  input  logic [ADDR_WIDTH-1:0]           paddr_i,
  input  logic [DATA_WIDTH-1:0]           pwdata_i,
  output logic [DATA_WIDTH-1:0]           prdata_o,
  output logic                            pready_o,
  output logic                            pslverr_o,
  output logic [NUM_PORTS-1:0]            reg_valid_o,
  output logic                            reg_write_o,
  output logic [ADDR_WIDTH-1:0]           reg_addr_o,
  output logic [DATA_WIDTH-1:0]           reg_wdata_o,
  output logic [3:0]                      reg_wstrb_o,
  input  logic [NUM_PORTS-1:0]            reg_ready_i,
  input  logic [NUM_PORTS-1:0]            reg_error_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] reg_rdata_i,
  output logic                            busy_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]      TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = (ADDR_WIDTH'(1) << PORT_ADDR_BITS) - ADDR_WIDTH'(1);
  localparam logic [NUM_PORTS-1:0]  ONE_HOT0 = NUM_PORTS'(1);
  localparam logic [DATA_WIDTH-1:0] TO_DATA  = DATA_WIDTH'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_r, state_next_s;
  logic [IDX_W-1:0]        idx_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [NUM_PORTS-1:0]    valid_r;
  logic                    write_r, pready_r, pslverr_r, busy_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r, prdata_r;
  logic [3:0]              wstrb_r;

  logic [ADDR_WIDTH-1:0]   off_s, idx_full_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    miss_s, access_s, accept_s, reject_s, handshake_s, timeout_s;
  logic                    ready_sel_s, error_sel_s;
  logic [DATA_WIDTH-1:0]   rdata_sel_s;
  logic [DATA_WIDTH-1:0]   rdata_arr_s [NUM_PORTS];

  // Address decode of the current APB access
  always_comb begin
    off_s      = paddr_i - BASE_ADDR;
    idx_full_s = off_s >> PORT_ADDR_BITS;
    idx_s      = idx_full_s[IDX_W-1:0];
    miss_s     = (paddr_i < BASE_ADDR) || (idx_full_s >= ADDR_WIDTH'(NUM_PORTS));
    access_s   = psel_i && penable_i;
  end

  // Select the response of the port currently being addressed
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rdata_arr_s[i] = reg_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
    ready_sel_s = reg_ready_i[idx_r];
    error_sel_s = reg_error_i[idx_r];
    rdata_sel_s = rdata_arr_s[idx_r];
  end

  // Next-state logic; a ready in the timeout cycle takes priority over the timeout
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    handshake_s  = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s && miss_s) begin
          reject_s     = 1'b1;
          state_next_s = RESP;
        end else if (access_s) begin
          accept_s     = 1'b1;
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (ready_sel_s) begin
          handshake_s  = 1'b1;
          state_next_s = RESP;
        end else if (TO_EN && (cnt_r == TO_LAST)) begin
          timeout_s    = 1'b1;
          state_next_s = RESP;
        end else begin
          state_next_s = REQ;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Request and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_r     <= {IDX_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      valid_r   <= {NUM_PORTS{1'b0}};
      write_r   <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
      wstrb_r   <= 4'h0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      pready_r <= (state_next_s == RESP);
      if (accept_s) begin
        idx_r   <= idx_s;
        cnt_r   <= {CNT_W{1'b0}};
        valid_r <= ONE_HOT0 << idx_s;
        write_r <= pwrite_i;
        addr_r  <= off_s & OFF_MASK;
        wdata_r <= pwdata_i;
        wstrb_r <= 4'hF;
      end else if (reject_s) begin
        pslverr_r <= 1'b1;
        prdata_r  <= {DATA_WIDTH{1'b0}};
      end else if (handshake_s) begin
        valid_r   <= {NUM_PORTS{1'b0}};
        wstrb_r   <= 4'h0;
        pslverr_r <= error_sel_s;
        prdata_r  <= write_r ? {DATA_WIDTH{1'b0}} : rdata_sel_s;
      end else if (timeout_s) begin
        valid_r   <= {NUM_PORTS{1'b0}};
        wstrb_r   <= 4'h0;
        pslverr_r <= 1'b1;
        prdata_r  <= TO_DATA;
      end else if (state_r == REQ) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else if (state_r == RESP) begin
        pslverr_r <= 1'b0;
        prdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign prdata_o    = prdata_r;
  assign pready_o    = pready_r;
  assign pslverr_o   = pslverr_r;
  assign reg_valid_o = valid_r;
  assign reg_write_o = write_r;
  assign reg_addr_o  = addr_r;
  assign reg_wdata_o = wdata_r;
  assign reg_wstrb_o = wstrb_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_apb_reg_demux.sv
// Self-checking bench for apb_reg_demux: table of APB accesses against a wait-state
// target model, with a scoreboard of expected responses and hand sequences for reset cases.
module tb_apb_reg_demux;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0] paddr_i = 32'h0, pwdata_i = 32'h0;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o, reg_write_o, busy_o;
  logic [3:0]  reg_valid_o, reg_ready_i, reg_error_i, reg_wstrb_o;
  logic [31:0] reg_addr_o, reg_wdata_o;
  logic [127:0] reg_rdata_i;

  apb_reg_demux #(
    .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .PORT_ADDR_BITS(12), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o), .reg_valid_o(reg_valid_o),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o), .reg_ready_i(reg_ready_i), .reg_error_i(reg_error_i),
    .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          port;
    int          wait_c;
    logic [31:0] tdata;
    logic        terr;
    logic [3:0]  exp_valid;
    int          exp_vcyc;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  vec_t post_rst;
  vec_t sb[$];

  int checks = 0;
  int failures = 0;

  // Target model: addressed port answers after tgt_wait cycles, others answer at once with junk
  int          tgt_port = 0;
  int          tgt_wait = 0;
  logic [31:0] tgt_data = 32'h0;
  logic        tgt_err  = 1'b0;
  int          vcnt[4];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < 4; p++) vcnt[p] <= 0;
    end else begin
      for (int p = 0; p < 4; p++)
        vcnt[p] <= (reg_valid_o[p] && !reg_ready_i[p]) ? vcnt[p] + 1 : 0;
    end
  end

  always_comb begin
    reg_ready_i = 4'h0;
    reg_error_i = 4'h0;
    reg_rdata_i = 128'h0;
    for (int p = 0; p < 4; p++) begin
      if (p == tgt_port) begin
        reg_ready_i[p] = reg_valid_o[p] && (vcnt[p] >= tgt_wait);
        reg_error_i[p] = tgt_err;
        reg_rdata_i[p*32 +: 32] = tgt_data;
      end else begin
        reg_ready_i[p] = reg_valid_o[p];
        reg_error_i[p] = ~tgt_err;
        reg_rdata_i[p*32 +: 32] = ~tgt_data;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One APB access; entered and left just after a rising edge so accesses run back to back
  task automatic run_vec(input vec_t v);
    int          cyc = 0, vcyc = 0;
    logic        got = 1'b0, onehot_ok = 1'b1, stable_ok = 1'b1, quiet_ok = 1'b1, busy_ok = 1'b1;
    logic [3:0]  vor = 4'h0, c_wstrb = 4'h0;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0, r_data = 32'h0;
    logic        c_write = 1'b0, r_err = 1'b0;
    vec_t        e;
    tgt_port = v.port; tgt_wait = v.wait_c; tgt_data = v.tdata; tgt_err = v.terr;
    sb.push_back(v);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = v.write; paddr_i = v.addr; pwdata_i = v.wdata;
    @(posedge clk_i); #1 penable_i = 1'b1;
    @(posedge clk_i);
    while (!got && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (!busy_o) busy_ok = 1'b0;
      if (reg_valid_o != 4'h0) begin
        if (!$onehot(reg_valid_o)) onehot_ok = 1'b0;
        if (vcyc == 0) begin
          c_addr = reg_addr_o; c_wdata = reg_wdata_o; c_write = reg_write_o; c_wstrb = reg_wstrb_o;
        end else if (c_addr !== reg_addr_o || c_wdata !== reg_wdata_o ||
                     c_write !== reg_write_o || c_wstrb !== reg_wstrb_o) begin
          stable_ok = 1'b0;
        end
        vcyc++;
        vor |= reg_valid_o;
      end
      if (pready_o) begin
        got = 1'b1; r_data = prdata_o; r_err = pslverr_o;
      end else if (prdata_o != 32'h0 || pslverr_o) begin
        quiet_ok = 1'b0;
      end
    end
    chk({v.name, ".pready_seen"}, {31'h0, got}, 32'h1);
    if (got) begin
      chk({v.name, ".sb_nonempty"}, sb.size(), 32'h1);
      e = sb.pop_front();
      chk({e.name, ".prdata"},  r_data, e.exp_rdata);
      chk({e.name, ".pslverr"}, {31'h0, r_err}, {31'h0, e.exp_err});
      chk({e.name, ".valid"},   {28'h0, vor}, {28'h0, e.exp_valid});
      chk({e.name, ".vcycles"}, vcyc, e.exp_vcyc);
      chk({e.name, ".latency"}, cyc, e.exp_vcyc + 1);
      chk({e.name, ".onehot"},  {31'h0, onehot_ok}, 32'h1);
      chk({e.name, ".stable"},  {31'h0, stable_ok}, 32'h1);
      chk({e.name, ".quiet"},   {31'h0, quiet_ok}, 32'h1);
      chk({e.name, ".busy"},    {31'h0, busy_ok}, 32'h1);
      if (e.exp_valid != 4'h0) begin
        chk({e.name, ".reg_addr"},  c_addr, e.exp_addr);
        chk({e.name, ".reg_write"}, {31'h0, c_write}, {31'h0, e.write});
        chk({e.name, ".reg_wstrb"}, {28'h0, c_wstrb}, 32'hF);
        if (e.write) chk({e.name, ".reg_wdata"}, c_wdata, e.wdata);
      end
    end
    @(posedge clk_i); #1;
    chk({v.name, ".pready_1cyc"}, {31'h0, pready_o}, 32'h0);
    chk({v.name, ".idle_after"},  {31'h0, busy_o}, 32'h0);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    //          name        addr            wr    wdata          port wait tdata          terr  valid  vcyc addr      rdata          err
    vecs[0] = '{"wr_hit",   BASE+32'h1004, 1'b1, 32'hA5A5_0001, 1,   0,   32'h0000_0000, 1'b0, 4'b0010, 1, 32'h004, 32'h0000_0000, 1'b0};
    vecs[1] = '{"rd_wait",  BASE+32'h3010, 1'b0, 32'h0,         3,   5,   32'h1234_5678, 1'b0, 4'b1000, 6, 32'h010, 32'h1234_5678, 1'b0};
    vecs[2] = '{"miss_hi",  BASE+32'h4000, 1'b0, 32'h0,         0,   0,   32'h1111_1111, 1'b0, 4'b0000, 0, 32'h000, 32'h0000_0000, 1'b1};
    vecs[3] = '{"miss_lo",  32'h3FFF_FFFC, 1'b0, 32'h0,         0,   0,   32'h2222_2222, 1'b0, 4'b0000, 0, 32'h000, 32'h0000_0000, 1'b1};
    vecs[4] = '{"timeout",  BASE+32'h0020, 1'b0, 32'h0,         0,   1000,32'h5555_AAAA, 1'b0, 4'b0001, 8, 32'h020, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{"late_rdy", BASE+32'h0024, 1'b0, 32'h0,         0,   7,   32'hCAFE_0001, 1'b0, 4'b0001, 8, 32'h024, 32'hCAFE_0001, 1'b0};
    vecs[6] = '{"wr_err",   BASE+32'h2FFC, 1'b1, 32'h0F0F_F0F0, 2,   2,   32'h7777_7777, 1'b1, 4'b0100, 3, 32'hFFC, 32'h0000_0000, 1'b1};
    vecs[7] = '{"rd_err",   BASE+32'h2008, 1'b0, 32'h0,         2,   0,   32'h1111_2222, 1'b1, 4'b0100, 1, 32'h008, 32'h1111_2222, 1'b1};
    post_rst = '{"post_rst",BASE+32'h0004, 1'b0, 32'h0,         0,   1,   32'h0BAD_F00D, 1'b0, 4'b0001, 2, 32'h004, 32'h0BAD_F00D, 1'b0};

    // Reset held with random APB activity: every output must stay 0
    tgt_port = 0; tgt_wait = 0; tgt_data = 32'h0; tgt_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      psel_i = 1'($urandom_range(0, 1)); penable_i = 1'($urandom_range(0, 1));
      pwrite_i = 1'($urandom_range(0, 1)); paddr_i = BASE + 32'($urandom_range(0, 32'h3FFF));
      pwdata_i = $urandom;
      @(negedge clk_i);
      chk("reset_outputs", {prdata_o, pready_o, pslverr_o, reg_valid_o, reg_write_o, reg_addr_o,
                            reg_wdata_o, reg_wstrb_o, busy_o} == 0 ? 32'h0 : 32'h1, 32'h0);
    end
    psel_i = 1'b0; penable_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("reset_busy", {31'h0, busy_o}, 32'h0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a request to port 2
    tgt_port = 2; tgt_wait = 1000; tgt_data = 32'h0; tgt_err = 1'b0;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = BASE + 32'h2000;
    @(posedge clk_i); #1 penable_i = 1'b1;
    @(posedge clk_i);
    repeat (3) @(negedge clk_i);
    chk("midrst.valid_before", {28'h0, reg_valid_o}, 32'h4);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst.valid_drop", {28'h0, reg_valid_o}, 32'h0);
    chk("midrst.busy",       {31'h0, busy_o}, 32'h0);
    chk("midrst.pready",     {31'h0, pready_o}, 32'h0);
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_vec(post_rst);

    chk("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_reg_demux.md
Name: apb_reg_demux

Overview:
- Parametrised APB3 slave that decodes one APB target window into NUM_PORTS independent register-bus request/response ports.
- Successor to the single-target APB-to-register bridge. Sits behind the AXI-to-APB converter in a core's register interface, so one AXI slave can serve several register files (CIM core control, DMA, status).
- Adds the following beyond the single-target bridge:
  - address decode with decode-error response;
  - per-access timeout;
  - registered, single-outstanding response path.

Parameters:
- NUM_PORTS, 4: number of register-bus target ports; range 1..16.
- ADDR_WIDTH, 32: APB and register-bus address width.
- DATA_WIDTH, 32: data width; fixed at 32 (APB3).
- BASE_ADDR, 32'h0000_0000: base of the decoded window.
- PORT_ADDR_BITS, 12: log2 of each port's window size in bytes; port i covers BASE_ADDR + i*2^PORT_ADDR_BITS.
- TIMEOUT_CYCLES, 255: maximum cycles reg_valid_o may stay high without reg_ready_i; 0 disables the timeout.

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: asynchronous active-low reset.
- psel_i, input, 1: APB select.
- penable_i, input, 1: APB enable.
- pwrite_i, input, 1: APB write.
- paddr_i, input, ADDR_WIDTH: APB address.
- pwdata_i, input, 32: APB write data.
- prdata_o, output, 32: APB read data.
- pready_o, output, 1: APB ready.
- pslverr_o, output, 1: APB error.
- reg_valid_o, output, NUM_PORTS: one-hot request valid, one bit per port.
- reg_write_o, output, 1: request is a write (shared by all ports).
- reg_addr_o, output, ADDR_WIDTH: byte offset within the port window, zero-extended (shared).
- reg_wdata_o, output, 32: write data (shared).
- reg_wstrb_o, output, 4: byte strobes; always 4'hF (shared).
- reg_ready_i, input, NUM_PORTS: per-port ready.
- reg_error_i, input, NUM_PORTS: per-port error, sampled with ready.
- reg_rdata_i, input, NUM_PORTS*32: per-port read data; port i occupies bits [32*i+31:32*i].
- busy_o, output, 1: high whenever the FSM is not IDLE.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0 during and after reset; FSM in IDLE; timeout counter 0.
- Reset mid-transfer: reg_valid_o drops immediately; no response is issued; the APB master must restart the access.
- Decode:
  - off = paddr_i - BASE_ADDR; idx = off >> PORT_ADDR_BITS.
  - Miss if paddr_i < BASE_ADDR or idx >= NUM_PORTS.
  - reg_addr_o = off & (2^PORT_ADDR_BITS - 1).
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Waits for psel_i & penable_i (access phase); the setup phase is ignored.
  - Hit: latch idx, write flag, offset and wdata into output registers; assert reg_valid_o[idx] from the next cycle; clear the counter; go to REQ.
  - Miss: go to RESP with pslverr = 1 and prdata = 0; no reg_valid_o bit is asserted.
- REQ:
  - reg_valid_o[idx] and all request fields stay stable until the handshake.
  - Handshake on reg_valid_o[idx] & reg_ready_i[idx] at a clock edge.
    - Capture reg_error_i[idx] as pslverr.
    - Capture reg_rdata_i[idx] as prdata, or 0 for a write.
    - Drop valid; go to RESP.
  - Counter increments each REQ cycle without ready.
  - Timeout, only when TIMEOUT_CYCLES != 0: counter == TIMEOUT_CYCLES-1 with no ready means valid was high exactly TIMEOUT_CYCLES cycles. Then drop valid, set pslverr = 1 and prdata = 32'hDEAD_BEEF, go to RESP.
  - Ready and timeout in the same cycle: the handshake wins.
- RESP: pready_o = 1 for exactly one cycle with registered prdata_o and pslverr_o; return to IDLE. prdata_o and pslverr_o are 0 outside RESP.
- Latency, zero-wait target (ready tied high):
  - Access phase sampled at edge E0; valid high in cycle E0..E1.
  - Handshake at E1; pready high in cycle E1..E2.
  - The APB access completes at E2, giving 2 wait states.
  - A target with k extra wait cycles adds k.
- Single outstanding: no new access is accepted until RESP completes. A back-to-back APB access is taken in IDLE on the cycle after RESP.
- Protocol violation (psel_i dropped during REQ): the register-side transaction still completes; RESP is still issued for one cycle; the APB inputs are ignored until IDLE.
- Only reg_valid_o[idx] is ever asserted; every other bit stays 0 (one-hot or zero at all times).

Test Plan:
- Reset: hold rst_ni low 5 cycles with random APB inputs -> every output 0. Release rst_ni -> busy_o 0.
- Write hit, zero wait: write 32'hA5A5_0001 to BASE+0x1_004, port 1 ready tied high.
  - reg_valid_o = 4'b0010, reg_addr_o = 0x004, reg_write_o = 1, reg_wstrb_o = 4'hF for exactly 1 cycle.
  - pready_o high 1 cycle later with pslverr_o = 0.
- Read hit with wait: read BASE+0x3_010, port 3 ready after 5 cycles with rdata 32'h1234_5678.
  - reg_valid_o[3] held 6 cycles.
  - prdata_o = 32'h1234_5678 with pready_o; pslverr_o = 0.
- Decode miss: read BASE+0x4_000 with NUM_PORTS = 4.
  - reg_valid_o stays 0.
  - One cycle after the access phase: pready_o = 1, pslverr_o = 1, prdata_o = 0.
- Timeout: TIMEOUT_CYCLES = 8, port 0 never ready.
  - reg_valid_o[0] high exactly 8 cycles.
  - Then pready_o = 1, pslverr_o = 1, prdata_o = 32'hDEAD_BEEF.
  - A second test: ready asserted in cycle 8 gives a normal response.
- Reset mid-REQ: assert rst_ni low while reg_valid_o[2] = 1 -> valid drops immediately. After release, the next access to port 0 completes normally.
